oci_dct_trace_packer: RTL

//  Packs 2-bit per-instruction trace codes from the Nios II OCI into 30-bit

---
 rtl/oci_dct_trace_packer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/oci_dct_trace_packer.sv
// Packs 2-bit OCI trace codes into 30-bit frames and hands closed frames downstream on valid/ready.
// Optional DCT_DROP_COUNTER_EN adds a saturating drop counter and marks the first frame closed after a drop.
//
// state | meaning
// IDLE  | accumulator empty
// FILL  | accumulator holds codes, no close pending
// PEND  | frame closed but output slot busy; incoming codes are dropped
module oci_dct_trace_packer #(
  parameter int unsigned CODES_PER_FRAME = 15,
  parameter bit          FLUSH_ON_EXC    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tr_valid,
  input  logic [1:0]  tr_code,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic        overflow
`ifdef DCT_DROP_COUNTER_EN
  ,
  output logic [15:0] drop_count
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t      state_q, state_d;
  logic [29:0] acc_q, acc_d, app_buf, ld_data;
  logic [3:0]  cnt_q, cnt_d, app_cnt, ld_cnt;
  logic        slot_free, accept, drop, close, load_frame;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // In PEND nothing is accepted, so app_* equals the held accumulator.
  always_comb begin
    slot_free = !frame_valid || frame_ready;
    accept    = tr_valid && (state_q != PEND);
    drop      = tr_valid && (state_q == PEND);
    app_buf   = accept ? (acc_q | (30'(tr_code) << {cnt_q, 1'b0})) : acc_q;
    app_cnt   = cnt_q + 4'(accept);
    close     = (state_q != PEND) &&
                ((accept && (app_cnt == 4'(CODES_PER_FRAME))) ||
                 (flush && (app_cnt != 4'd0)) ||
                 (accept && FLUSH_ON_EXC && (tr_code == 2'b11)));
    case (state_q)
      PEND:    state_d = slot_free ? IDLE : PEND;
      default: begin
        if (close)                state_d = slot_free ? IDLE : PEND;
        else if (app_cnt == 4'd0) state_d = IDLE;
        else                      state_d = FILL;
      end
    endcase
  end

`ifdef DCT_DROP_COUNTER_EN
  logic mark_arm_q, mark_pend_q, mark_use;
`endif

  always_comb begin
    load_frame = slot_free && (close || (state_q == PEND));
    acc_d      = load_frame ? 30'd0 : app_buf;
    cnt_d      = load_frame ? 4'd0 : app_cnt;
    ld_data    = app_buf;
    ld_cnt     = app_cnt;
`ifdef DCT_DROP_COUNTER_EN
    mark_use = (state_q == PEND) ? mark_pend_q : mark_arm_q;
    if (mark_use) begin
      ld_data[29] = 1'b1;
      if (app_cnt > 4'd14) ld_cnt = 4'd14;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (load_frame) begin
        frame_valid <= 1'b1;
        frame_data  <= ld_data;
        frame_count <= ld_cnt;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef DCT_DROP_COUNTER_EN
  // Drops only happen in PEND and closes only outside it, so arm/consume never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count  <= '0;
      mark_arm_q  <= 1'b0;
      mark_pend_q <= 1'b0;
    end else begin
      if (ovf_clr)                          drop_count <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (drop)       mark_arm_q <= 1'b1;
      else if (close) mark_arm_q <= 1'b0;
      if (close && !slot_free)                   mark_pend_q <= mark_arm_q;
      else if (state_q == PEND && slot_free)     mark_pend_q <= 1'b0;
    end
  end
`endif

  assign dct_buffer = acc_q;
  assign dct_count  = cnt_q;

endmodule
